// File: rtl/alu_exec.sv
// Execute-stage ALU: two-stage valid/ready pipeline (operand register, result register)
// with full backpressure, zero/illegal flags and a saturating illegal-op counter.
module alu_exec #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_control,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  function automatic logic is_legal(input logic [3:0] code);
    return (code == OP_AND) || (code == OP_OR) || (code == OP_ADD) ||
           (code == OP_SUB) || (code == OP_SLT);
  endfunction

  logic             s1_valid_q;
  logic [3:0]       s1_op_q;
  logic [XLEN-1:0]  s1_a_q;
  logic [XLEN-1:0]  s1_b_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [XLEN-1:0]  s2_result_q;
  logic             s2_zero_q;
  logic             s2_illegal_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic [CNT_W-1:0] cnt_q;

  logic             s2_adv;
  logic             in_fire;
  logic [XLEN-1:0]  alu_res_d;
  logic             alu_ill_d;

  // S2 can take a new op when it is empty or being drained this cycle.
  assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    alu_res_d = '0;
    alu_ill_d = 1'b0;
    case (s1_op_q)
      OP_AND:  alu_res_d = s1_a_q & s1_b_q;
      OP_OR:   alu_res_d = s1_a_q | s1_b_q;
      OP_ADD:  alu_res_d = s1_a_q + s1_b_q;
      OP_SUB:  alu_res_d = s1_a_q - s1_b_q;
      OP_SLT:  alu_res_d = {{(XLEN-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      default: alu_ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_zero_q    <= 1'b0;
      s2_illegal_q <= 1'b0;
      s2_tag_q     <= '0;
      cnt_q        <= '0;
    end else begin
      if (in_fire) begin
        s1_op_q  <= in_alu_control;
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_tag_q <= in_tag;
      end
      if (in_fire) begin
        s1_valid_q <= 1'b1;
      end else if (s2_adv) begin
        s1_valid_q <= 1'b0;
      end

      // A simultaneous drain and advance keeps S2 full with the newer op.
      if (s2_adv) begin
        s2_valid_q   <= 1'b1;
        s2_result_q  <= alu_res_d;
        s2_zero_q    <= (alu_res_d == '0);
        s2_illegal_q <= alu_ill_d;
        s2_tag_q     <= s1_tag_q;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end

      if (in_fire && !is_legal(in_alu_control) && !(&cnt_q)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_result    = s2_result_q;
  assign out_zero      = s2_zero_q;
  assign out_illegal   = s2_illegal_q;
  assign out_tag       = s2_tag_q;
  assign illegal_count = cnt_q;

endmodule
